wb_cmd_sequencer: RTL

//  Synthesizable, parametrised Wishbone bus master that drains a queue of register commands
//  (write, read, wait-for-interrupt) into a Wishbone slave such as the IICMB core.

---
 rtl/wb_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// wb_cmd_sequencer
//
// Wishbone bus master that drains a small queue of register commands (write,
// read, wait-for-interrupt) into a Wishbone slave. Each command produces
// exactly one response, in order, with read data and an error flag. A bounded
// wait on ack_i / irq_i aborts a stuck access and reports an error.
//
// Ports
//   clk_i, rst_i                 clock (posedge) and synchronous active-high reset
//   irq_i                        slave interrupt, level-sensitive
//   cmd_valid_i / cmd_ready_o    command handshake (ready = FIFO not full)
//   cmd_op_i                     00 write, 01 read, 10 wait-irq, 11 reserved
//   cmd_adr_i / cmd_dat_i        target address / write data
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_dat_o / rsp_err_o        read data (0 for non-reads) / timeout-or-reserved flag
//   cyc_o, stb_o, we_o           Wishbone master controls (registered)
//   adr_o, dat_o                 Wishbone address / write data (registered)
//   dat_i, ack_i                 Wishbone read data / acknowledge
//   busy_o                       FSM active or commands still queued
// -----------------------------------------------------------------------------
module wb_cmd_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,

    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,

    output logic                  busy_o
);

    localparam int PTR_W = $clog2(CMD_DEPTH);

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_IRQ = 2'b10;

    typedef struct packed {
        logic [1:0]            op;
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_IRQW,
        S_RESP
    } state_t;

    state_t state;

    // -------------------------------------------------------------------------
    // Command FIFO. Pointers carry one extra wrap bit so full and empty are
    // distinguishable without a separate occupancy counter.
    // -------------------------------------------------------------------------
    cmd_t             mem [CMD_DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign cmd_in.op  = cmd_op_i;
    assign cmd_in.adr = cmd_adr_i;
    assign cmd_in.dat = cmd_dat_i;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign cmd_ready_o = !full;
    assign push        = cmd_valid_i && !full;
    // The head is consumed only when the FSM is free to start it.
    assign pop         = (state == S_IDLE) && !empty;
    assign head        = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= cmd_in;
    end

    // -------------------------------------------------------------------------
    // Wait timer. Runs only while waiting on ack_i or irq_i and is held at
    // zero everywhere else, so it is implicitly cleared on entry to a wait.
    // With TIMEOUT = 0 the timer disappears and waits are unbounded.
    // -------------------------------------------------------------------------
    logic tmo;

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int TW = $clog2(TIMEOUT + 1);
            logic [TW-1:0] timer;

            always_ff @(posedge clk_i) begin
                if (rst_i || !((state == S_BUS) || (state == S_IRQW)))
                    timer <= '0;
                else
                    timer <= timer + 1'b1;
            end

            assign tmo = (timer == TW'(TIMEOUT - 1));
        end else begin : g_no_timer
            assign tmo = 1'b0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered bus and response outputs.
    // BUS and IRQW always pass through RESP and IDLE before the next command,
    // which guarantees cyc_o is low for at least one cycle between transfers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        adr_o     <= head.adr;
                        dat_o     <= head.dat;
                        rsp_dat_o <= '0;
                        rsp_err_o <= 1'b0;
                        case (head.op)
                            OP_WR: begin
                                cyc_o <= 1'b1;
                                stb_o <= 1'b1;
                                we_o  <= 1'b1;
                                state <= S_BUS;
                            end
                            OP_RD: begin
                                cyc_o <= 1'b1;
                                stb_o <= 1'b1;
                                we_o  <= 1'b0;
                                state <= S_BUS;
                            end
                            OP_IRQ: begin
                                we_o  <= 1'b0;
                                state <= S_IRQW;
                            end
                            default: begin
                                // Reserved opcode: answer immediately with an error.
                                we_o        <= 1'b0;
                                rsp_err_o   <= 1'b1;
                                rsp_valid_o <= 1'b1;
                                state       <= S_RESP;
                            end
                        endcase
                    end
                end

                S_BUS: begin
                    // An ack on the same edge as the timeout still completes the access.
                    if (ack_i) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        we_o        <= 1'b0;
                        rsp_dat_o   <= we_o ? '0 : dat_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                    end else if (tmo) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        we_o        <= 1'b0;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                    end
                end

                S_IRQW: begin
                    if (irq_i) begin
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                    end else if (tmo) begin
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Hold the response until the consumer takes it; the FIFO
                    // keeps accepting commands meanwhile.
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != S_IDLE) || !empty;

endmodule
